// File: rtl/jtdsp16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtdsp16_pkg
// Description : Shared definitions for the DSP16 data-RAM arbiter. Holds the
//               default RAM geometry, the default host wait budget and the
//               host-side sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package jtdsp16_pkg;

    localparam int C_AW       = 11;   // RAM address width
    localparam int C_DW       = 16;   // RAM data width
    localparam int C_MAX_WAIT = 8;    // host cycles lost before the core is stalled

    // Host transaction sequencer states.
    // S_ISSUE is the cycle the host owns the RAM port. It is the WAIT cycle
    // the host wins, so it is never held in the state register.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_RD    = 3'd3,
        S_ACK   = 3'd4
    } host_state_t;

endpackage : jtdsp16_pkg
`default_nettype wire

// File: rtl/jtdsp16_ram_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : jtdsp16_ram_arb_if
// Description : Bundle of the core, host and RAM-macro signals of the DSP16
//               data-RAM arbiter.
//               slave  : the arbiter side (core/host requests in, RAM out)
//               master : the environment side (core, host and RAM macro)
// Ports       : core  ph1, core_rd, core_wr, core_addr, core_din,
//                     core_dout, core_stall
//               host  host_req, host_we, host_addr, host_din, host_dout,
//                     host_ack
//               ram   ram_addr, ram_we, ram_din, ram_dout
// Revision    : 1.0 - initial release
// ============================================================================
interface jtdsp16_ram_arb_if
#(
    parameter int AW = jtdsp16_pkg::C_AW,
    parameter int DW = jtdsp16_pkg::C_DW
);
    // Core (YAAU / datapath)
    logic          ph1;
    logic          core_rd;
    logic          core_wr;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_din;
    logic [DW-1:0] core_dout;
    logic          core_stall;
    // Host (debug / DMA)
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_din;
    logic [DW-1:0] host_dout;
    logic          host_ack;
    // RAM macro
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  ph1, core_rd, core_wr, core_addr, core_din,
        output core_dout, core_stall,
        input  host_req, host_we, host_addr, host_din,
        output host_dout, host_ack,
        output ram_addr, ram_we, ram_din,
        input  ram_dout
    );

    modport master (
        output ph1, core_rd, core_wr, core_addr, core_din,
        input  core_dout, core_stall,
        output host_req, host_we, host_addr, host_din,
        input  host_dout, host_ack,
        input  ram_addr, ram_we, ram_din,
        output ram_dout
    );

endinterface : jtdsp16_ram_arb_if
`default_nettype wire

// File: rtl/jtdsp16_ram_arb_fsm.sv
`default_nettype none
// ============================================================================
// Module      : jtdsp16_ram_arb_fsm
// Description : Host transaction sequencer and wait counter of the DSP16
//               data-RAM arbiter. The host waits for a cycle with no core
//               slot; after MAX_WAIT lost cycles the core is frozen for one
//               cycle so the host can issue.
// Ports       : clk, rst_n      clock, synchronous active-low reset
//               host_req        host request level (sampled only in IDLE)
//               host_we         host write(1) / read(0)
//               core_slot       core owns the RAM this cycle
//               issue           host drives the RAM this cycle
//               capture         RAM read data for the host is valid now
//               host_ack        one-cycle completion pulse
//               core_stall      freeze request to the core sequencer
// Revision    : 1.0 - initial release
// ============================================================================
module jtdsp16_ram_arb_fsm
    import jtdsp16_pkg::*;
#(
    parameter int MAX_WAIT = C_MAX_WAIT
)(
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic host_req,
    input  wire logic host_we,
    input  wire logic core_slot,
    output logic      issue,
    output logic      capture,
    output logic      host_ack,
    output logic      core_stall
);

    localparam int c_CW = $clog2(MAX_WAIT + 1);

    host_state_t     r_state;
    host_state_t     w_phase;
    logic [c_CW-1:0] r_wait_cnt;
    logic            r_capture;
    logic            r_ack;
    logic            r_stall;

    // A WAIT cycle without a core slot is the host issue cycle.
    always_comb begin
        w_phase = r_state;
        if (r_state == S_WAIT && !core_slot) begin
            w_phase = S_ISSUE;
        end
    end

    assign issue      = (w_phase == S_ISSUE);
    assign capture    = r_capture;
    assign host_ack   = r_ack;
    assign core_stall = r_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_capture  <= 1'b0;
            r_ack      <= 1'b0;
            r_stall    <= 1'b0;
        end else begin
            r_capture <= 1'b0;
            r_ack     <= 1'b0;
            r_stall   <= 1'b0;
            case (w_phase)
                S_IDLE: begin
                    if (host_req) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    // Only reached when the core took the slot. Once the
                    // budget is used up the stall removes the core slot in
                    // the next cycle, so the counter never passes MAX_WAIT.
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (r_wait_cnt == c_CW'(MAX_WAIT - 1)) begin
                        r_stall <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (host_we) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                    end else begin
                        r_state   <= S_RD;
                        r_capture <= 1'b1;
                    end
                end
                S_RD: begin
                    r_state <= S_ACK;
                    r_ack   <= 1'b1;
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : jtdsp16_ram_arb_fsm
`default_nettype wire

// File: rtl/jtdsp16_ram_arb.sv
`default_nettype none
// ============================================================================
// Module      : jtdsp16_ram_arb
// Description : Arbiter for the single-port DSP16 data RAM (synchronous read,
//               1-cycle latency). The core (ph1-qualified loads/stores) has
//               priority; the host port gets the free cycles and stalls the
//               core for one cycle when it has waited too long.
// Ports       : clk    single clock
//               rst_n  synchronous active-low reset
//               bus    jtdsp16_ram_arb_if.slave: core, host and RAM signals
// Revision    : 1.0 - initial release
// ============================================================================
module jtdsp16_ram_arb
    import jtdsp16_pkg::*;
#(
    parameter int AW       = C_AW,
    parameter int DW       = C_DW,
    parameter int MAX_WAIT = C_MAX_WAIT
)(
    input  wire logic        clk,
    input  wire logic        rst_n,
    jtdsp16_ram_arb_if.slave bus
);

    logic          w_core_slot;
    logic          w_issue;
    logic          w_capture;
    logic          w_host_ack;
    logic          w_core_stall;
    logic [DW-1:0] r_host_dout;

    // A core request during a stall is dropped; the core sequencer retries.
    assign w_core_slot = bus.ph1 & (bus.core_rd | bus.core_wr) & ~w_core_stall;

    // The host issue cycle only exists without a core slot, so the mux
    // select alone decides who owns the port. rd&wr together is a write.
    assign bus.ram_addr = w_core_slot ? bus.core_addr : bus.host_addr;
    assign bus.ram_din  = w_core_slot ? bus.core_din  : bus.host_din;
    assign bus.ram_we   = rst_n & (w_core_slot ? bus.core_wr : (w_issue & bus.host_we));

    assign bus.core_dout  = bus.ram_dout;
    assign bus.core_stall = w_core_stall;
    assign bus.host_ack   = w_host_ack;
    assign bus.host_dout  = r_host_dout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_host_dout <= '0;
        end else if (w_capture) begin
            r_host_dout <= bus.ram_dout;
        end
    end

    jtdsp16_ram_arb_fsm #(
        .MAX_WAIT   (MAX_WAIT)
    ) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_req   (bus.host_req),
        .host_we    (bus.host_we),
        .core_slot  (w_core_slot),
        .issue      (w_issue),
        .capture    (w_capture),
        .host_ack   (w_host_ack),
        .core_stall (w_core_stall)
    );

endmodule : jtdsp16_ram_arb
`default_nettype wire
